ultrasonido_ctrl: RTL

HC-SR04 ranging front end that sits directly upstream of the digit-display/servo stage. It issues periodic trigger pulses, times the returned echo with a divider-free counter chain, and presents the result in whole centimetres on a 33-bit `distance` bus. The display stage consumes that bus continuously, and the one-cycle `valid` strobe marks each new sample.

---
 rtl/ultrasonido_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ultrasonido_ctrl.sv
`timescale 1ns/1ps
// HC-SR04 ranging front end: periodic trigger, echo timing through a
// divider-free prescaler -> microsecond -> centimetre counter chain.
module ultrasonido_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TRIG_US      = 10,
  parameter int CM_US        = 58,
  parameter int PERIOD_US    = 60000,
  parameter int ECHO_WAIT_US = 30000,
  parameter int MAX_CM       = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  output logic        trig,
  output logic [32:0] distance,
  output logic        valid,
  output logic        timeout
);

  localparam int US_CYC     = CLK_HZ / 1_000_000;
  localparam int TRIG_CYC   = TRIG_US * US_CYC;
  localparam int PERIOD_CYC = PERIOD_US * US_CYC;
  localparam int WAIT_CYC   = ECHO_WAIT_US * US_CYC;
  localparam int TMR_MAX    = (TRIG_CYC > WAIT_CYC) ? TRIG_CYC : WAIT_CYC;

  localparam int PER_W = $clog2(PERIOD_CYC + 1);
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam int PRE_W = $clog2(US_CYC + 1);
  localparam int USC_W = $clog2(CM_US + 1);

  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYC - 1);
  localparam logic [PER_W-1:0] PER_ONE   = PER_W'(1);
  localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(US_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [USC_W-1:0] US_LAST   = USC_W'(CM_US - 1);
  localparam logic [USC_W-1:0] US_ONE    = USC_W'(1);
  localparam logic [8:0]       CM_MAX    = 9'(MAX_CM);
  localparam logic [8:0]       CM_ONE    = 9'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_echo_s1;
  logic             r_echo_s2;
  logic             r_echo_d;
  logic [PER_W-1:0] r_per_cnt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [USC_W-1:0] r_us_cnt;
  logic [USC_W-1:0] w_us_nxt;
  logic [8:0]       r_cm_cnt;
  logic [8:0]       w_cm_nxt;
  logic             r_trig;
  logic [32:0]      r_distance;
  logic             r_valid;
  logic             r_timeout;
  logic             w_rise;
  logic             w_fall;

  assign w_rise = r_echo_s2 & ~r_echo_d;
  assign w_fall = ~r_echo_s2 & r_echo_d;

  assign trig     = r_trig;
  assign distance = r_distance;
  assign valid    = r_valid;
  assign timeout  = r_timeout;

  // A no-echo timeout loads MAX_CM into the cm counter, so DONE publishes
  // every outcome from r_cm_cnt and flags timeout whenever it equals MAX_CM.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_pre_nxt   = r_pre_cnt;
    w_us_nxt    = r_us_cnt;
    w_cm_nxt    = r_cm_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_per_cnt == '0) begin
          w_state_nxt = S_TRIG;
          w_tmr_nxt   = '0;
        end
      end
      S_TRIG: begin
        if (r_tmr == TRIG_LAST) begin
          w_state_nxt = S_WAIT;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + TMR_ONE;
        end
      end
      S_WAIT: begin
        if (w_rise) begin
          w_state_nxt = S_MEAS;
          w_pre_nxt   = '0;
          w_us_nxt    = '0;
          w_cm_nxt    = '0;
        end else if (r_tmr == WAIT_LAST) begin
          w_state_nxt = S_DONE;
          w_cm_nxt    = CM_MAX;
        end else begin
          w_tmr_nxt = r_tmr + TMR_ONE;
        end
      end
      S_MEAS: begin
        if (r_cm_cnt == CM_MAX) begin
          w_state_nxt = S_DONE;
        end else begin
          if (r_pre_cnt == PRE_LAST) begin
            w_pre_nxt = '0;
            if (r_us_cnt == US_LAST) begin
              w_us_nxt = '0;
              w_cm_nxt = r_cm_cnt + CM_ONE;
            end else begin
              w_us_nxt = r_us_cnt + US_ONE;
            end
          end else begin
            w_pre_nxt = r_pre_cnt + PRE_ONE;
          end
          if (w_fall) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_echo_s1  <= 1'b0;
      r_echo_s2  <= 1'b0;
      r_echo_d   <= 1'b0;
      r_per_cnt  <= '0;
      r_tmr      <= '0;
      r_pre_cnt  <= '0;
      r_us_cnt   <= '0;
      r_cm_cnt   <= '0;
      r_trig     <= 1'b0;
      r_distance <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
      r_per_cnt <= (r_per_cnt == PER_LAST) ? '0 : r_per_cnt + PER_ONE;
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_pre_cnt <= w_pre_nxt;
      r_us_cnt  <= w_us_nxt;
      r_cm_cnt  <= w_cm_nxt;
      r_trig    <= (r_state == S_TRIG);
      r_valid   <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_distance <= {24'd0, r_cm_cnt};
        r_timeout  <= (r_cm_cnt == CM_MAX);
      end
    end
  end

endmodule
